// File: rtl/burst_fsm_pkg.sv
// Shared encodings for the burst sequencer: state values, error codes, count width helper.
// Pure declarations; no latency or flow control of its own.
package burst_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_PROCESS  = 3'd2,
        S_COMPLETE = 3'd3,
        S_ERROR    = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ZERO    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    function automatic int cnt_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/burst_timeout_cnt.sv
// Idle timer: counts enabled cycles; expired flags the cycle whose count reaches TIMEOUT.
// Zero latency on expired (combinational from count and enable); no backpressure.
module burst_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    // Holding TIMEOUT-1 is enough: the enabled cycle at that count is the TIMEOUT-th one.
    assign expired = en && !clear && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/burst_proc_fsm.sv
// Burst controller: start -> START -> PROCESS accumulating beats -> done/error pulse; Moore outputs.
// Done arrives the cycle after the last beat; upstream is stalled by data_ready outside PROCESS.
module burst_proc_fsm
    import burst_fsm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 15,
    localparam int CNT_W    = cnt_w(MAX_BEATS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  beats,
    input  logic              abort,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ready,
    output logic              ready,
    output logic              processing,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [CNT_W-1:0] ONE_BEAT = CNT_W'(1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    beats_q, beats_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [1:0]          err_code_q, err_code_d;

    logic                in_process;
    logic                accept;
    logic [DATA_W-1:0]   acc_sum;
    logic                tmo_clear;
    logic                tmo_en;
    logic                tmo_expired;

    assign in_process = (state_q == S_PROCESS);
    // Abort wins over a beat presented in the same cycle, so that beat is never counted.
    assign accept     = in_process && data_valid && !abort;
    assign acc_sum    = acc_q + data_in;
    assign tmo_clear  = !in_process || accept;
    assign tmo_en     = in_process && !accept && !abort;

    burst_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        acc_d      = acc_q;
        data_out_d = data_out_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    beats_d    = beats;
                    beat_cnt_d = '0;
                    acc_d      = '0;
                    data_out_d = '0;
                    err_code_d = ERR_NONE;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (abort) begin
                    err_code_d = ERR_ABORT;
                    state_d    = S_ERROR;
                end else if (beats_q == '0) begin
                    err_code_d = ERR_ZERO;
                    state_d    = S_ERROR;
                end else begin
                    state_d    = S_PROCESS;
                end
            end
            S_PROCESS: begin
                if (abort) begin
                    err_code_d = ERR_ABORT;
                    state_d    = S_ERROR;
                end else if (accept) begin
                    acc_d      = acc_sum;
                    beat_cnt_d = beat_cnt_q + ONE_BEAT;
                    if ((beat_cnt_q + ONE_BEAT) == beats_q) begin
                        data_out_d = acc_sum;
                        state_d    = S_COMPLETE;
                    end
                end else if (tmo_expired) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERROR;
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            S_ERROR:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
            err_code_q <= err_code_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign processing = (state_q == S_START) || in_process;
    assign data_ready = in_process;
    assign done       = (state_q == S_COMPLETE);
    assign error      = (state_q == S_ERROR);
    assign err_code   = err_code_q;
    assign beat_cnt   = beat_cnt_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_burst_proc_fsm.sv
// Directed bench for burst_proc_fsm: a table of bursts with hand-computed results plus
// hand-written sequences for reset, ignored start/abort and mid-burst reset.
module tb_burst_proc_fsm;

    localparam int NV = 9;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [4:0] beats;
    logic       abort;
    logic       data_valid;
    logic [7:0] data_in;
    logic       data_ready;
    logic       ready;
    logic       processing;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [4:0] beat_cnt;
    logic [7:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int               beats;
        int               nwords;
        int               gap;
        int               abort_at;   // -1 none, -2 abort during START, else word index
        logic [15:0][7:0] dat;
        bit               exp_done;
        int               exp_cycle;
        logic [7:0]       exp_dout;
        logic [1:0]       exp_err;
        int               exp_cnt;
        bit               exp_no_dready;
    } vec_t;

    vec_t vecs [NV];

    burst_proc_fsm #(
        .DATA_W    (8),
        .MAX_BEATS (16),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .beats      (beats),
        .abort      (abort),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_ready (data_ready),
        .ready      (ready),
        .processing (processing),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .beat_cnt   (beat_cnt),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int b, input int nw, input int gp, input int ab,
                           input bit ed, input int ec, input logic [7:0] eo, input logic [1:0] ee,
                           input int en, input bit nd);
        vecs[i].beats         = b;
        vecs[i].nwords        = nw;
        vecs[i].gap           = gp;
        vecs[i].abort_at      = ab;
        vecs[i].dat           = '0;
        vecs[i].exp_done      = ed;
        vecs[i].exp_cycle     = ec;
        vecs[i].exp_dout      = eo;
        vecs[i].exp_err       = ee;
        vecs[i].exp_cnt       = en;
        vecs[i].exp_no_dready = nd;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   cyc;
        int   w;
        int   g;
        bit   seen_dr;
        bit   finished;
        v = vecs[i];
        start = 1'b1;
        beats = 5'(v.beats);
        step();
        start    = 1'b0;
        cyc      = 1;
        w        = 0;
        g        = 0;
        seen_dr  = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < 300 && !finished; k++) begin
            data_valid = 1'b0;
            abort      = 1'b0;
            if (done || error) begin
                finished = 1'b1;
            end else begin
                if (data_ready) begin
                    seen_dr = 1'b1;
                    if (w < v.nwords) begin
                        if (g < v.gap) begin
                            g++;
                        end else begin
                            data_valid = 1'b1;
                            data_in    = v.dat[w];
                            abort      = (w == v.abort_at);
                            w++;
                            g = 0;
                        end
                    end
                end else if (processing && v.abort_at == -2) begin
                    abort = 1'b1;
                end
                step();
                cyc++;
            end
        end
        check($sformatf("v%0d_finished", i), finished, 1);
        if (finished) begin
            check($sformatf("v%0d_done", i), done, v.exp_done);
            check($sformatf("v%0d_error", i), error, !v.exp_done);
            check($sformatf("v%0d_cycle", i), cyc, v.exp_cycle);
            check($sformatf("v%0d_data_out", i), data_out, v.exp_dout);
            check($sformatf("v%0d_err_code", i), err_code, v.exp_err);
            check($sformatf("v%0d_beat_cnt", i), beat_cnt, v.exp_cnt);
            if (v.exp_no_dready) check($sformatf("v%0d_no_dready", i), seen_dr, 0);
            step();
            check($sformatf("v%0d_pulse_end", i), {done, error}, 2'b00);
            check($sformatf("v%0d_ready_after", i), ready, 1);
            check($sformatf("v%0d_dout_held", i), data_out, v.exp_dout);
        end
    endtask

    initial begin
        int cyc;
        int bad;
        reset_n    = 1'b0;
        start      = 1'b0;
        beats      = '0;
        abort      = 1'b0;
        data_valid = 1'b0;
        data_in    = '0;

        // burst vectors: expected cycle counts from the start edge (cycle 0)
        set_vec(0,  4,  4, 0, -1, 1,  6, 8'hA0, 2'b00,  4, 0);
        vecs[0].dat[0] = 8'h10; vecs[0].dat[1] = 8'h20; vecs[0].dat[2] = 8'h30; vecs[0].dat[3] = 8'h40;
        set_vec(1,  2,  2, 0, -1, 1,  4, 8'h01, 2'b00,  2, 0);
        vecs[1].dat[0] = 8'hFF; vecs[1].dat[1] = 8'h02;
        set_vec(2, 16, 16, 3, -1, 1, 66, 8'h88, 2'b00, 16, 0);
        for (int j = 0; j < 16; j++) vecs[2].dat[j] = 8'(j + 1);
        set_vec(3,  0,  0, 0, -1, 0,  2, 8'h00, 2'b01,  0, 1);
        set_vec(4,  3,  1, 0, -1, 0, 18, 8'h00, 2'b10,  1, 0);
        vecs[4].dat[0] = 8'h07;
        set_vec(5,  1,  1, 0, -1, 1,  3, 8'h05, 2'b00,  1, 0);
        vecs[5].dat[0] = 8'h05;
        set_vec(6,  4,  2, 0,  1, 0,  4, 8'h00, 2'b11,  1, 0);
        vecs[6].dat[0] = 8'h11; vecs[6].dat[1] = 8'h22;
        set_vec(7, 16, 16, 0, -1, 1, 18, 8'hF0, 2'b00, 16, 0);
        for (int j = 0; j < 16; j++) vecs[7].dat[j] = 8'hFF;
        set_vec(8,  5,  0, 0, -2, 0,  2, 8'h00, 2'b11,  0, 1);

        step();
        step();
        #2;
        reset_n = 1'b1;
        step();

        check("rst_ready", ready, 1);
        check("rst_processing", processing, 0);
        check("rst_done_error", {done, error}, 2'b00);
        check("rst_data_ready", data_ready, 0);
        check("rst_err_code", err_code, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_data_out", data_out, 0);

        // abort while idle has no effect
        abort = 1'b1;
        step();
        step();
        check("idle_abort_ready", ready, 1);
        check("idle_abort_error", error, 0);
        abort = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // start during PROCESS and during COMPLETE must both be ignored
        start = 1'b1;
        beats = 5'd2;
        step();
        check("rs_start_state", processing, 1);
        beats = 5'd9;
        step();
        data_valid = 1'b1;
        data_in    = 8'h03;
        step();
        data_in    = 8'h04;
        step();
        data_valid = 1'b0;
        check("rs_done", done, 1);
        check("rs_beat_cnt", beat_cnt, 2);
        check("rs_data_out", data_out, 8'h07);
        step();
        start = 1'b0;
        check("rs_idle_after_complete", {ready, processing}, 2'b10);
        step();
        check("rs_still_idle", {ready, processing}, 2'b10);

        // asynchronous reset in the middle of a burst
        start = 1'b1;
        beats = 5'd4;
        step();
        start = 1'b0;
        step();
        data_valid = 1'b1;
        data_in    = 8'h21;
        step();
        step();
        check("mid_beat_cnt", beat_cnt, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 1);
        check("mid_rst_processing", processing, 0);
        check("mid_rst_data_ready", data_ready, 0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_outputs", {done, error, err_code, data_out}, 0);
        step();
        step();
        #2;
        reset_n    = 1'b1;
        data_valid = 1'b0;
        bad        = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done || error || !ready) bad++;
        end
        check("post_rst_quiet", bad, 0);
        check("post_rst_beat_cnt", beat_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
